// File: rtl/fp32_stream_argmax_pkg.sv
// Shared fp32 field positions, constants and FSM state encoding for the
// streaming argmax stage and its comparator.
package fp32_stream_argmax_pkg;

  localparam int FP32_W   = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;

  localparam logic [FP32_W-1:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [FP32_W-1:0] FP32_NEG_INF  = 32'hFF80_0000;

  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_ACC   = 2'd1,
    S_OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/IEEE754_comparator.sv
// Combinational fp32 A >= B using sign-magnitude ordering; NaNs are ranked
// purely by bit pattern, and +0 ranks above -0.
module IEEE754_comparator
  import fp32_stream_argmax_pkg::*;
(
  input  logic [FP32_W-1:0] i_a,
  input  logic [FP32_W-1:0] i_b,
  output logic              o_ge
);

  logic              w_sign_a;
  logic              w_sign_b;
  logic [EXP_MSB:0]  w_mag_a;
  logic [EXP_MSB:0]  w_mag_b;

  assign w_sign_a = i_a[SIGN_BIT];
  assign w_sign_b = i_b[SIGN_BIT];
  assign w_mag_a  = i_a[EXP_MSB:0];
  assign w_mag_b  = i_b[EXP_MSB:0];

  always_comb begin
    o_ge = 1'b0;
    if (w_sign_a != w_sign_b) begin
      o_ge = !w_sign_a;
    end else if (!w_sign_a) begin
      o_ge = (w_mag_a >= w_mag_b);
    end else begin
      // Both negative: the larger magnitude is the smaller number.
      o_ge = (w_mag_a <= w_mag_b);
    end
  end

endmodule

// File: rtl/fp32_stream_argmax.sv
// Framed fp32 stream reduction: tracks running max and its beat index, then
// emits one result beat per frame (force-closed at MAX_LEN beats).
module fp32_stream_argmax
  import fp32_stream_argmax_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FP32_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [FP32_W-1:0] m_max,
  output logic [IDX_W-1:0]  m_index,
  output logic [IDX_W:0]    m_len,
  output logic              m_trunc,
  output logic [1:0]        o_dbg_state
);

  localparam int LEN_W = IDX_W + 1;
  localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAX_LEN);

  state_t            r_state;
  logic [FP32_W-1:0] r_max;
  logic [IDX_W-1:0]  r_idx;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_trunc;

  logic w_accept;
  logic w_ge;
  logic w_update;
  logic w_at_limit;

  // Handshakes: a beat transfers on any rising edge where valid && ready.
  // The source holds valid/data/last stable until that edge; s_ready is low
  // only while a result is pending, and m_valid holds its beat until m_ready.
  assign s_ready     = (r_state != S_OUT);
  assign m_valid     = (r_state == S_OUT);
  assign w_accept    = s_valid && s_ready;
  assign m_max       = r_max;
  assign m_index     = r_idx;
  assign m_len       = r_cnt;
  assign m_trunc     = r_trunc;
  assign o_dbg_state = r_state;

  IEEE754_comparator u_cmp (
    .i_a  (s_data),
    .i_b  (r_max),
    .o_ge (w_ge)
  );

  // Strictly greater only, so the earliest of equal values keeps its index.
  assign w_update   = w_ge && (s_data != r_max);
  assign w_at_limit = ((r_cnt + 1'b1) == LEN_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FIRST;
      r_max   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_trunc <= 1'b0;
    end else begin
      case (r_state)
        S_FIRST: begin
          if (w_accept) begin
            r_max <= s_data;
            r_idx <= '0;
            r_cnt <= LEN_W'(1);
            if (s_last || (MAX_LEN == 1)) begin
              r_state <= S_OUT;
              r_trunc <= !s_last;
            end else begin
              r_state <= S_ACC;
            end
          end
        end
        S_ACC: begin
          if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_update) begin
              r_max <= s_data;
              r_idx <= r_cnt[IDX_W-1:0];
            end
            if (s_last || w_at_limit) begin
              r_state <= S_OUT;
              r_trunc <= !s_last;
            end
          end
        end
        S_OUT: begin
          if (m_ready) begin
            r_state <= S_FIRST;
            r_trunc <= 1'b0;
          end
        end
        default: r_state <= S_FIRST;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_stream_argmax.sv
// Directed bench for fp32_stream_argmax: hand-computed frames covering ties,
// signed zeros, infinities, NaNs, truncation, backpressure, gaps and reset.
module tb_fp32_stream_argmax;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_max;
  logic [5:0]  m_index;
  logic [6:0]  m_len;
  logic        m_trunc;
  logic [1:0]  dbg_state;

  int total;
  int bad;

  fp32_stream_argmax #(.MAX_LEN(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_max       (m_max),
    .m_index     (m_index),
    .m_len       (m_len),
    .m_trunc     (m_trunc),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one beat and returns #1 after the edge that accepted it.
  task automatic send_beat(input logic [31:0] d, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL send_timeout s_ready=%b required=1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Waits (bounded) for a result, captures it, then completes the handshake.
  task automatic get_result(output logic got, output int lat,
                            output logic [31:0] mx, output logic [5:0] ix,
                            output logic [6:0] ln, output logic tr);
    lat = 0;
    while (!m_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    got = m_valid;
    mx = m_max; ix = m_index; ln = m_len; tr = m_trunc;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      bad++; $display("FAIL reset_hs m_valid=%b s_ready=%b required 0/1", m_valid, s_ready);
    end
    total++;
    if (m_max !== 32'h0 || m_index !== 6'd0 || m_len !== 7'd0 || m_trunc !== 1'b0) begin
      bad++; $display("FAIL reset_out max=%h idx=%0d len=%0d tr=%b required 0/0/0/0",
                      m_max, m_index, m_len, m_trunc);
    end
  endtask

  task automatic test_basic();
    logic got, tr; int lat; logic [31:0] mx; logic [5:0] ix; logic [6:0] ln;
    send_beat(32'h3F800000, 0); send_beat(32'h40200000, 0);
    send_beat(32'hC0400000, 0); send_beat(32'h40200000, 1);
    get_result(got, lat, mx, ix, ln, tr);
    total++;
    if (!got || lat != 0) begin
      bad++; $display("FAIL basic_latency got=%b lat=%0d required 1/0", got, lat);
    end
    total++;
    if (mx !== 32'h40200000 || ix !== 6'd1 || ln !== 7'd4 || tr !== 1'b0) begin
      bad++; $display("FAIL basic_tie max=%h idx=%0d len=%0d tr=%b required 40200000/1/4/0", mx, ix, ln, tr);
    end
    total++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      bad++; $display("FAIL basic_release m_valid=%b s_ready=%b required 0/1", m_valid, s_ready);
    end
    send_beat(32'hC0400000, 0); send_beat(32'hBF800000, 0); send_beat(32'hBF800000, 1);
    get_result(got, lat, mx, ix, ln, tr);
    total++;
    if (!got || mx !== 32'hBF800000 || ix !== 6'd1 || ln !== 7'd3 || tr !== 1'b0) begin
      bad++; $display("FAIL negative max=%h idx=%0d len=%0d tr=%b required BF800000/1/3/0", mx, ix, ln, tr);
    end
  endtask

  task automatic test_zero_inf_nan();
    logic got, tr; int lat; logic [31:0] mx; logic [5:0] ix; logic [6:0] ln;
    send_beat(32'h80000000, 0); send_beat(32'h00000000, 1);
    get_result(got, lat, mx, ix, ln, tr);
    total++;
    if (!got || mx !== 32'h00000000 || ix !== 6'd1 || ln !== 7'd2) begin
      bad++; $display("FAIL signed_zero max=%h idx=%0d len=%0d required 00000000/1/2", mx, ix, ln);
    end
    send_beat(32'h7F800000, 1);
    get_result(got, lat, mx, ix, ln, tr);
    total++;
    if (!got || mx !== 32'h7F800000 || ix !== 6'd0 || ln !== 7'd1 || tr !== 1'b0) begin
      bad++; $display("FAIL single_inf max=%h idx=%0d len=%0d tr=%b required 7F800000/0/1/0", mx, ix, ln, tr);
    end
    send_beat(32'h7F800000, 0); send_beat(32'h7FC00000, 1);
    get_result(got, lat, mx, ix, ln, tr);
    total++;
    if (!got || mx !== 32'h7FC00000 || ix !== 6'd1) begin
      bad++; $display("FAIL pos_nan max=%h idx=%0d required 7FC00000/1", mx, ix);
    end
    send_beat(32'hFF800000, 0); send_beat(32'hFFC00000, 1);
    get_result(got, lat, mx, ix, ln, tr);
    total++;
    if (!got || mx !== 32'hFF800000 || ix !== 6'd0 || ln !== 7'd2) begin
      bad++; $display("FAIL neg_nan max=%h idx=%0d len=%0d required FF800000/0/2", mx, ix, ln);
    end
  endtask

  task automatic test_trunc();
    logic got, tr; int lat; logic [31:0] mx; logic [5:0] ix; logic [6:0] ln;
    for (int i = 0; i < 64; i++) begin
      send_beat((i == 40) ? 32'h42C80000 : 32'h3F800000, 0);
    end
    get_result(got, lat, mx, ix, ln, tr);
    total++;
    if (!got || lat != 0 || tr !== 1'b1) begin
      bad++; $display("FAIL trunc_close got=%b lat=%0d tr=%b required 1/0/1", got, lat, tr);
    end
    total++;
    if (mx !== 32'h42C80000 || ix !== 6'd40 || ln !== 7'd64) begin
      bad++; $display("FAIL trunc_vals max=%h idx=%0d len=%0d required 42C80000/40/64", mx, ix, ln);
    end
    total++;
    if (m_trunc !== 1'b0) begin
      bad++; $display("FAIL trunc_clear tr=%b required 0", m_trunc);
    end
    send_beat(32'hBF800000, 1);
    get_result(got, lat, mx, ix, ln, tr);
    total++;
    if (!got || mx !== 32'hBF800000 || ix !== 6'd0 || ln !== 7'd1 || tr !== 1'b0) begin
      bad++; $display("FAIL trunc_next max=%h idx=%0d len=%0d tr=%b required BF800000/0/1/0", mx, ix, ln, tr);
    end
  endtask

  task automatic test_backpressure();
    logic got, tr; int lat; logic [31:0] mx; logic [5:0] ix; logic [6:0] ln;
    int errs;
    send_beat(32'h3F800000, 0); send_beat(32'h40A00000, 1);
    errs = 0;
    for (int c = 0; c < 5; c++) begin
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_max !== 32'h40A00000 ||
          m_index !== 6'd1 || m_len !== 7'd2) errs++;
      @(posedge clk); #1;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL hold_stable bad_cycles=%0d required 0 (max=%h idx=%0d len=%0d)",
                      errs, m_max, m_index, m_len);
    end
    get_result(got, lat, mx, ix, ln, tr);
    total++;
    if (!got || m_valid !== 1'b0 || s_ready !== 1'b1) begin
      bad++; $display("FAIL hold_release got=%b m_valid=%b s_ready=%b required 1/0/1", got, m_valid, s_ready);
    end
  endtask

  task automatic test_gaps();
    logic got, tr; int lat; logic [31:0] mx; logic [5:0] ix; logic [6:0] ln;
    send_beat(32'h3F800000, 0);
    repeat (3) @(posedge clk);
    #1 send_beat(32'h40000000, 0);
    repeat (2) @(posedge clk);
    #1 send_beat(32'h3FC00000, 1);
    get_result(got, lat, mx, ix, ln, tr);
    total++;
    if (!got || mx !== 32'h40000000 || ix !== 6'd1 || ln !== 7'd3) begin
      bad++; $display("FAIL gaps max=%h idx=%0d len=%0d required 40000000/1/3", mx, ix, ln);
    end
  endtask

  task automatic test_mid_reset();
    logic got, tr; int lat; logic [31:0] mx; logic [5:0] ix; logic [6:0] ln;
    int seen;
    send_beat(32'h42C80000, 0); send_beat(32'h43000000, 0);
    rst = 1'b1;
    #2;
    total++;
    if (dbg_state !== 2'd0 || m_max !== 32'h0 || m_len !== 7'd0) begin
      bad++; $display("FAIL async_reset state=%0d max=%h len=%0d required 0/0/0", dbg_state, m_max, m_len);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (m_valid !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL reset_no_out valid_cycles=%0d required 0", seen);
    end
    send_beat(32'h40A00000, 1);
    get_result(got, lat, mx, ix, ln, tr);
    total++;
    if (!got || mx !== 32'h40A00000 || ix !== 6'd0 || ln !== 7'd1 || tr !== 1'b0) begin
      bad++; $display("FAIL reset_fresh max=%h idx=%0d len=%0d tr=%b required 40A00000/0/1/0", mx, ix, ln, tr);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_zero_inf_nan();
    test_trunc();
    test_backpressure();
    test_gaps();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
